sd_background_update: RTL
=========================

# sd_background_update

Per-pixel sigma-delta background/variance update stage, directly downstream of the frame manager. Consumes the current luminance pixel plus the stored background and variance for the same location. Produces the updated background and variance, with a write strobe back to frame storage, and one motion bit per pixel for the motion-map path. Implemented as a fixed two-stage pipeline with a warm-up frame counter.

## Interface
- `N_AMP`, default 2: variance target amplification factor; integer 1–4.
- `V_MIN`, default 2: lower clamp for the variance.
- `V_MAX`, default 255: upper clamp for the variance; `V_MIN` ≤ `V_MAX` ≤ 255.
- `WARMUP_FRAMES`, default 1: number of initial frames used to seed the model; range 1–255.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: input acceptance gate.
- `in_valid`, in, 1: the input beat is valid.
- `curr_pixel`, in, 8: current frame luminance.
- `prev_pixel`, in, 8: stored background for the same pixel.
- `prev_variance`, in, 8: stored variance for the same pixel.
- `last_in_frame`, in, 1: the beat is the final pixel of its frame.
- `wr_background`, out, 1: write strobe for `background_next` and `variance_next`.
- `background_next`, out, 8: updated background.
- `variance_next`, out, 8: updated variance.
- `motion_bit`, out, 1: motion decision for the pixel.
- `out_last`, out, 1: end-of-frame marker, aligned with `wr_background`.
- `warm_done`, out, 1: high once `WARMUP_FRAMES` frames have completed.

## Operation
- A beat is accepted when `in_valid` & `enable`.
- When `enable`=0, stage 1 loads a bubble (valid=0) and stage 2 still advances. The pipeline drains; beats are never duplicated or frozen.
- Stage 1 registers `curr`, `bg`, `var` and `last`. It also computes `diff` = |curr − bg| (9-bit signed subtract, 8-bit magnitude) and `dir_bg` = sign(curr − bg).
- Stage 2 runs in steady state (`warm_done`=1):
  - `background_next` = bg + `dir_bg`, i.e. one step of +1, −1 or 0. No wrap is possible.
  - `target` = min(`N_AMP`·diff, 255), computed in 10 bits and then saturated.
  - If diff ≠ 0: `variance_next` = var + sign(target − var). If diff = 0: `variance_next` = var.
  - The result is then clamped to [`V_MIN`, `V_MAX`].
  - `motion_bit` = (diff > `variance_next`).
- Stage 2 in warm-up (`warm_done`=0): `background_next` = curr, `variance_next` = `V_MIN`, `motion_bit` = 0.
- Warm-up counter (8-bit):
  - Increments on each stage-2 output beat that carries `last`.
  - Saturates at `WARMUP_FRAMES`.
  - `warm_done` = (count == `WARMUP_FRAMES`).
  - The beat that completes warm-up is itself still processed in warm-up mode.
- A stored `prev_variance` outside [`V_MIN`, `V_MAX`] is clamped before comparison, so the output is always in range.

## Timing
- Latency is fixed at 2 cycles. A beat accepted at edge k appears on the outputs after edge k+2.
- `wr_background` is high for exactly 1 cycle per accepted beat. Throughput is 1 beat per cycle.
- `out_last` equals `wr_background` & stored `last`.
- All outputs are registered.
- Reset values:
  - `wr_background`, `out_last`, `motion_bit` and `warm_done` are 0.
  - `background_next` and `variance_next` are 0.
  - Both pipeline valids are 0 and the warm-up counter is 0.
- Reset asserted mid-frame:
  - In-flight beats are discarded with no write strobe.
  - The counter clears, so warm-up reruns from the next accepted beat.
- If `enable` drops while `last_in_frame` is in flight, that beat still completes and counts.

## Structure
- Shared package `motion_pkg`:
  - `PIX_W` = 8.
  - Pixel typedef `pix_t`.
  - Functions `sat8(10-bit)→pix_t` and `clamp(v, lo, hi)`.
- Sub-module `sd_step`: combinational helper that takes `cur`, `target` and `en`, and returns `cur` moved one LSB toward `target`.
  - Instanced twice: once for the background (target = curr, en = 1) and once for the variance (target = `target`, en = diff ≠ 0).
- Top-level contents: the two pipeline register banks and the warm-up counter.

## Test plan
- Reset/warm-up (`WARMUP_FRAMES`=1). Stimulus: a 4-pixel frame with curr=80, bg=0, var=0, last on pixel 4. Response:
  - 4 strobes with `background_next`=80, `variance_next`=2, `motion_bit`=0.
  - `warm_done` rises 1 cycle after the `out_last` beat.
- Motion. Stimulus (steady state): curr=100, bg=50, var=10, `N_AMP`=2. Response: `background_next`=51, `variance_next`=11, `motion_bit`=1.
- No motion. Stimulus: curr=52, bg=50, var=10. Response: `background_next`=51, `variance_next`=9, `motion_bit`=0.
- Equality and clamping:
  - curr=bg=30, var=2: outputs 30 / 2 / 0.
  - curr=0, bg=255, var=255, `V_MAX`=200: `background_next`=254, `variance_next`=200, `motion_bit`=1.
- Enable gap. Stimulus: 3 back-to-back beats with `enable` low for 2 cycles mid-stream. Response:
  - Exactly 3 strobes.
  - Each strobe appears 2 cycles after its acceptance edge.
  - No duplicates.
- Async reset. Stimulus: assert `rst` mid-frame with 2 beats in flight. Response:
  - All outputs are 0 immediately, with no strobe.
  - Post-reset traffic is treated as warm-up (`motion_bit`=0, `variance_next`=`V_MIN`).

Source files
------------

// File: rtl/motion_pkg.sv
// Shared pixel types and helpers for the motion-detection datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package motion_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  // Saturate a 10-bit unsigned value to the 8-bit pixel range.
  function automatic pix_t sat8(input logic [9:0] v);
    return (v[9:8] != 2'b00) ? 8'hFF : v[7:0];
  endfunction

  // Clamp v into [lo, hi]; callers guarantee lo <= hi.
  function automatic pix_t clamp(input pix_t v, input pix_t lo, input pix_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/sd_step.sv
// Sigma-delta step: moves cur one LSB toward target when en is set.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cur (current value), target (value to approach), en (step enable),
//        nxt (cur, cur+1 or cur-1).
module sd_step
  import motion_pkg::*;
(
  input  logic [PIX_W-1:0] cur,
  input  logic [PIX_W-1:0] target,
  input  logic             en,
  output logic [PIX_W-1:0] nxt
);

  // The +1 only happens when target > cur and the -1 only when target < cur,
  // so the result can never wrap.
  always_comb begin
    nxt = cur;
    if (en) begin
      if (target > cur) begin
        nxt = cur + 8'd1;
      end else if (target < cur) begin
        nxt = cur - 8'd1;
      end
    end
  end

endmodule

// File: rtl/sd_background_update.sv
// Per-pixel sigma-delta background/variance update with motion bit and warm-up.
// Latency: fixed 2 cycles from the accepting edge to registered outputs.
// Backpressure: none; enable=0 injects a bubble and the pipeline keeps draining.
// Ports: clk/rst (async active-high); enable, in_valid, curr_pixel,
//        prev_pixel, prev_variance and last_in_frame are the input beat;
//        wr_background, background_next, variance_next, motion_bit and
//        out_last are the result beat; warm_done flags seeding complete.
module sd_background_update
  import motion_pkg::*;
#(
  parameter int N_AMP         = 2,
  parameter int V_MIN         = 2,
  parameter int V_MAX         = 255,
  parameter int WARMUP_FRAMES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       in_valid,
  input  logic [7:0] curr_pixel,
  input  logic [7:0] prev_pixel,
  input  logic [7:0] prev_variance,
  input  logic       last_in_frame,
  output logic       wr_background,
  output logic [7:0] background_next,
  output logic [7:0] variance_next,
  output logic       motion_bit,
  output logic       out_last,
  output logic       warm_done
);

  localparam pix_t       VMIN = pix_t'(V_MIN);
  localparam pix_t       VMAX = pix_t'(V_MAX);
  localparam logic [7:0] WARM = 8'(WARMUP_FRAMES);
  localparam logic [9:0] AMP  = 10'(N_AMP);

  // Stage 1: captured input beat.
  logic s1_vld_q, s1_last_q;
  pix_t s1_curr_q, s1_bg_q, s1_var_q;

  // Stage 1 -> 2 datapath: absolute difference via a 9-bit subtract.
  logic [8:0] sub_d, neg_d;
  pix_t       diff_d;

  // Stage 2: beat plus difference, variance already clamped into range.
  logic s2_vld_q, s2_last_q;
  pix_t s2_curr_q, s2_bg_q, s2_var_q, s2_diff_q;

  // Stage 2 update datapath.
  logic [9:0] amp_d;
  pix_t       target_d, bg_step_d, var_step_d, var_cl_d;
  logic       steady_d;

  // Output registers and warm-up counter.
  logic       wr_q, last_q, mo_q, warm_q;
  pix_t       bg_q, var_q;
  pix_t       out_bg_d, out_var_d;
  logic       out_mo_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    sub_d  = {1'b0, s1_curr_q} - {1'b0, s1_bg_q};
    neg_d  = 9'd0 - sub_d;
    diff_d = sub_d[8] ? neg_d[7:0] : sub_d[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_curr_q <= '0;
      s1_bg_q   <= '0;
      s1_var_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_curr_q <= '0;
      s2_bg_q   <= '0;
      s2_var_q  <= '0;
      s2_diff_q <= '0;
    end else begin
      s1_vld_q  <= in_valid & enable;
      s1_last_q <= last_in_frame;
      s1_curr_q <= curr_pixel;
      s1_bg_q   <= prev_pixel;
      s1_var_q  <= prev_variance;
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_curr_q <= s1_curr_q;
      s2_bg_q   <= s1_bg_q;
      // A stored variance outside the legal range is pulled in before use.
      s2_var_q  <= clamp(s1_var_q, VMIN, VMAX);
      s2_diff_q <= diff_d;
    end
  end

  // N_AMP <= 4 keeps the product within 10 bits before saturation.
  always_comb begin
    amp_d    = {2'b00, s2_diff_q} * AMP;
    target_d = sat8(amp_d);
  end

  sd_step u_bg_step (
    .cur    (s2_bg_q),
    .target (s2_curr_q),
    .en     (1'b1),
    .nxt    (bg_step_d)
  );

  sd_step u_var_step (
    .cur    (s2_var_q),
    .target (target_d),
    .en     (s2_diff_q != 8'd0),
    .nxt    (var_step_d)
  );

  // Warm-up counter counts end-of-frame beats as they leave the outputs.
  always_comb begin
    cnt_d = cnt_q;
    if (out_last_q_w() && (cnt_q != WARM)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  function automatic logic out_last_q_w();
    return last_q;
  endfunction

  // Looking at cnt_d lets the beat right behind a warm-up-completing last
  // beat already use the steady-state update.
  always_comb begin
    var_cl_d  = clamp(var_step_d, VMIN, VMAX);
    steady_d  = (cnt_d == WARM);
    out_bg_d  = bg_step_d;
    out_var_d = var_cl_d;
    out_mo_d  = (s2_diff_q > var_cl_d);
    if (!steady_d) begin
      out_bg_d  = s2_curr_q;
      out_var_d = VMIN;
      out_mo_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      last_q <= 1'b0;
      mo_q   <= 1'b0;
      bg_q   <= '0;
      var_q  <= '0;
      cnt_q  <= '0;
      warm_q <= 1'b0;
    end else begin
      wr_q   <= s2_vld_q;
      last_q <= s2_vld_q & s2_last_q;
      cnt_q  <= cnt_d;
      warm_q <= (cnt_d == WARM);
      if (s2_vld_q) begin
        mo_q  <= out_mo_d;
        bg_q  <= out_bg_d;
        var_q <= out_var_d;
      end
    end
  end

  assign wr_background   = wr_q;
  assign out_last        = last_q;
  assign motion_bit      = mo_q;
  assign background_next = bg_q;
  assign variance_next   = var_q;
  assign warm_done       = warm_q;

endmodule
